// File: rtl/tick_ctrl_pkg.sv
// tick_ctrl shared types and constants.
// State encoding, mode codes and the reset divide ratio.
package tick_ctrl_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic MODE_PERIODIC = 1'b0;
    localparam logic MODE_ONESHOT  = 1'b1;

    localparam int unsigned TICK_DEFAULT_DIV = 6250000;

endpackage

// File: rtl/tick_ctrl_if.sv
// tick_ctrl configuration port.
// valid/ready handshake carrying divide ratio and mode.
interface tick_ctrl_if #(
    parameter int WIDTH = 23
);
    logic             cfg_valid;
    logic             cfg_ready;
    logic [WIDTH-1:0] cfg_div;
    logic             cfg_mode;

    modport master (
        output cfg_valid,
        output cfg_div,
        output cfg_mode,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid,
        input  cfg_div,
        input  cfg_mode,
        output cfg_ready
    );
endinterface

// File: rtl/tick_ctrl_counter.sv
// tick_counter: WIDTH-bit counter with clear, enable and terminal value.
// o_wrap is a combinational strobe; the owner registers it.
module tick_counter #(
    parameter int WIDTH = 23
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clr,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_term,
    output logic [WIDTH-1:0] o_count,
    output logic             o_wrap
);
    logic [WIDTH-1:0] r_count;

    assign o_wrap  = i_en && (r_count == i_term);
    assign o_count = r_count;

    // count up to the terminal value, then fold back to zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= o_wrap ? '0 : r_count + 1'b1;
        end
    end
endmodule

// File: rtl/tick_ctrl.sv
// tick_ctrl: programmable tick-enable scheduler on CLOCK_50.
// Define TICK_CTRL_ONESHOT_EN to enable one-shot mode and done.
module tick_ctrl
    import tick_ctrl_pkg::*;
#(
    parameter int          WIDTH       = 23,
    parameter int unsigned DEFAULT_DIV = TICK_DEFAULT_DIV
) (
    input  logic             CLOCK_50,
    input  logic             reset,
    tick_ctrl_if.slave       cfg,
    input  logic             start,
    input  logic             stop,
    output logic             tick,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] count
);
    localparam logic [WIDTH-1:0] DIV_RST = WIDTH'(DEFAULT_DIV);

    state_t           r_state;
    logic [WIDTH-1:0] r_div;
    logic [WIDTH-1:0] r_term;
    logic             r_tick;

    logic             w_run;
    logic             w_accept;
    logic             w_clr;
    logic             w_en;
    logic             w_wrap;
    logic [WIDTH-1:0] w_load_term;

    assign w_run    = (r_state == ST_RUN);
    assign w_accept = cfg.cfg_valid && cfg.cfg_ready;
    assign w_clr    = !w_run || start || stop;
    assign w_en     = w_run && !start && !stop;

    // a ratio of zero behaves as one
    assign w_load_term = (r_div == '0) ? '0 : r_div - 1'b1;

    assign cfg.cfg_ready = !w_run;
    assign busy          = w_run;
    assign tick          = r_tick;

    tick_counter #(
        .WIDTH (WIDTH)
    ) u_cnt (
        .clk     (CLOCK_50),
        .rst_n   (reset),
        .i_clr   (w_clr),
        .i_en    (w_en),
        .i_term  (r_term),
        .o_count (count),
        .o_wrap  (w_wrap)
    );

`ifdef TICK_CTRL_ONESHOT_EN
    logic r_mode;
    logic r_run_mode;
    logic r_done;

    assign done = r_done;

    // config registers load only on an accepted request
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            r_div  <= DIV_RST;
            r_mode <= MODE_PERIODIC;
        end else if (w_accept) begin
            r_div  <= cfg.cfg_div;
            r_mode <= cfg.cfg_mode;
        end
    end

    // run FSM; ratio and mode are latched at start
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_term     <= '0;
            r_run_mode <= MODE_PERIODIC;
            r_tick     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_tick <= 1'b0;
            r_done <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    if (start && !stop) begin
                        r_state    <= ST_RUN;
                        r_term     <= w_load_term;
                        r_run_mode <= r_mode;
                    end
                end
                ST_RUN: begin
                    if (stop) begin
                        r_state <= ST_IDLE;
                    end else if (start) begin
                        r_term     <= w_load_term;
                        r_run_mode <= r_mode;
                    end else if (w_wrap) begin
                        r_tick <= 1'b1;
                        if (r_run_mode == MODE_ONESHOT) begin
                            r_done  <= 1'b1;
                            r_state <= ST_IDLE;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end
`else
    logic w_unused_mode;

    assign w_unused_mode = cfg.cfg_mode;
    assign done          = 1'b0;

    // divide ratio loads only on an accepted request
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            r_div <= DIV_RST;
        end else if (w_accept) begin
            r_div <= cfg.cfg_div;
        end
    end

    // run FSM; ratio is latched at start, always periodic
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_term  <= '0;
            r_tick  <= 1'b0;
        end else begin
            r_tick <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    if (start && !stop) begin
                        r_state <= ST_RUN;
                        r_term  <= w_load_term;
                    end
                end
                ST_RUN: begin
                    if (stop) begin
                        r_state <= ST_IDLE;
                    end else if (start) begin
                        r_term <= w_load_term;
                    end else if (w_wrap) begin
                        r_tick <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end
`endif
endmodule

// File: tb/tb_tick_ctrl.sv
// Directed bench for tick_ctrl with DEFAULT_DIV shortened to 8.
// Honours TICK_CTRL_ONESHOT_EN for the one-shot expectations.
module tb_tick_ctrl;
    localparam int W = 23;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         stop;
    logic         tick;
    logic         busy;
    logic         done;
    logic [W-1:0] count;

    int n_chk;
    int n_pass;

    tick_ctrl_if #(.WIDTH(W)) cfg_if ();

    tick_ctrl #(
        .WIDTH       (W),
        .DEFAULT_DIV (8)
    ) dut (
        .CLOCK_50 (clk),
        .reset    (rst_n),
        .cfg      (cfg_if.slave),
        .start    (start),
        .stop     (stop),
        .tick     (tick),
        .busy     (busy),
        .done     (done),
        .count    (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (obs === exp) begin
            n_pass = n_pass + 1;
        end else begin
            $display("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_wr(input int div, input logic mode);
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_div   = W'(div);
        cfg_if.cfg_mode  = mode;
        step();
        cfg_if.cfg_valid = 1'b0;
    endtask

    task automatic go();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic halt();
        stop = 1'b1;
        step();
        stop = 1'b0;
    endtask

    task automatic exp_ticks(input string tag,
                             input int n,
                             input int per);
        for (int i = 1; i <= n; i++) begin
            step();
            chk(tag, 32'(tick), 32'((i % per) == 0));
        end
    endtask

    initial begin
        n_chk  = 0;
        n_pass = 0;
        rst_n  = 1'b0;
        start  = 1'b0;
        stop   = 1'b0;
        cfg_if.cfg_valid = 1'b0;
        cfg_if.cfg_div   = '0;
        cfg_if.cfg_mode  = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("rst_ready", 32'(cfg_if.cfg_ready), 1);
        chk("rst_tick", 32'(tick), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_count", 32'(count), 0);
        chk("rst_done", 32'(done), 0);
        step();
        chk("idle_busy", 32'(busy), 0);

        // default ratio 8
        go();
        chk("def_busy", 32'(busy), 1);
        chk("def_ready", 32'(cfg_if.cfg_ready), 0);
        chk("def_cnt0", 32'(count), 0);
        exp_ticks("def_tick", 9, 8);
        chk("def_cnt1", 32'(count), 1);
        halt();
        chk("def_stop", 32'(busy), 0);

        // N=4 periodic, stop at k+10
        cfg_wr(4, 1'b0);
        go();
        exp_ticks("n4_tick", 9, 4);
        halt();
        chk("n4_stop_busy", 32'(busy), 0);
        chk("n4_stop_tick", 32'(tick), 0);
        chk("n4_stop_cnt", 32'(count), 0);
        chk("n4_ready", 32'(cfg_if.cfg_ready), 1);
        exp_ticks("n4_quiet", 3, 1000);

        // N=0 and N=1 tick every cycle
        cfg_wr(0, 1'b0);
        go();
        exp_ticks("n0_tick", 4, 1);
        chk("n0_cnt", 32'(count), 0);
        halt();
        cfg_wr(1, 1'b0);
        go();
        exp_ticks("n1_tick", 4, 1);
        halt();

        // N=5 one-shot
        cfg_wr(5, 1'b1);
        go();
        exp_ticks("os_tick", 4, 5);
        step();
        chk("os_tick5", 32'(tick), 1);
`ifdef TICK_CTRL_ONESHOT_EN
        chk("os_done", 32'(done), 1);
        chk("os_busy", 32'(busy), 0);
        chk("os_ready", 32'(cfg_if.cfg_ready), 1);
        step();
        chk("os_tick_off", 32'(tick), 0);
        chk("os_done_off", 32'(done), 0);
`else
        chk("os_done", 32'(done), 0);
        chk("os_busy", 32'(busy), 1);
        exp_ticks("os_per", 5, 5);
        halt();
`endif

        // N=6, restart at count=3
        cfg_wr(6, 1'b0);
        go();
        repeat (3) step();
        chk("rp_cnt3", 32'(count), 3);
        go();
        chk("rp_cnt0", 32'(count), 0);
        chk("rp_tick", 32'(tick), 0);
        chk("rp_busy", 32'(busy), 1);
        exp_ticks("rp_next", 6, 6);
        halt();

        // start+stop in IDLE stays IDLE
        start = 1'b1;
        stop  = 1'b1;
        step();
        start = 1'b0;
        stop  = 1'b0;
        chk("ss_busy", 32'(busy), 0);
        chk("ss_ready", 32'(cfg_if.cfg_ready), 1);
        step();
        chk("ss_cnt", 32'(count), 0);

        // config and start on the same edge
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_div   = W'(3);
        cfg_if.cfg_mode  = 1'b0;
        go();
        cfg_if.cfg_valid = 1'b0;
        exp_ticks("same_old", 6, 6);
        halt();
        go();
        exp_ticks("same_new", 6, 3);
        halt();

        // async reset mid-run restores default ratio
        cfg_wr(9, 1'b0);
        go();
        repeat (2) step();
        chk("ar_cnt2", 32'(count), 2);
        #1;
        rst_n = 1'b0;
        #1;
        chk("ar_busy", 32'(busy), 0);
        chk("ar_cnt", 32'(count), 0);
        chk("ar_tick", 32'(tick), 0);
        chk("ar_ready", 32'(cfg_if.cfg_ready), 1);
        #1;
        rst_n = 1'b1;
        go();
        exp_ticks("ar_div", 8, 8);
        halt();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/tick_ctrl.md
# tick_ctrl

Programmable tick scheduler that replaces fixed free-running clock division from `CLOCK_50` with a controlled, single-clock enable pulse. It accepts a divide ratio through a valid/ready config port and starts and stops on command. It emits a one-cycle `tick` every N cycles (periodic) or once (one-shot). Downstream logic uses `tick` as a clock enable on `CLOCK_50` instead of clocking from a counter bit.

## Interface
- `WIDTH`, 23: counter and divide-ratio width.
- `DEFAULT_DIV`, 6250000: divide ratio after reset (8 Hz at 50 MHz).
- `CLOCK_50`  in  1: the only clock, rising-edge.
- `reset`  in  1: asynchronous, active-low reset (0 = reset asserted).
- `cfg_valid`  in  1: config request.
- `cfg_ready`  out  1: config can be accepted; 1 only in IDLE.
- `cfg_div`  in  WIDTH: divide ratio N; 0 is treated as 1.
- `cfg_mode`  in  1: 0 = periodic, 1 = one-shot.
- `start`  in  1: start or restart the counter (level sampled per cycle).
- `stop`  in  1: stop the counter; has priority over `start`.
- `tick`  out  1: registered one-cycle pulse.
- `busy`  out  1: high in RUN.
- `done`  out  1: one-cycle pulse when a one-shot completes.
- `count`  out  WIDTH: current counter value.

## Operation
- States: IDLE and RUN.
- Reset values: state IDLE, `count`=0, `tick`=0, `busy`=0, `done`=0, `cfg_ready`=1, div register=`DEFAULT_DIV`, mode register=periodic.
- Config is accepted on an edge with `cfg_valid`&&`cfg_ready`.
  - On acceptance, the div and mode registers load.
  - While in RUN, `cfg_ready`=0 and requests wait.
  - The new ratio applies from the next start.
- IDLE→RUN: `start`=1 and `stop`=0 at an edge; `count`←0.
- RUN, no start or stop: `count` increments each cycle.
  - When `count`==N-1, `count`←0 and `tick`←1 for that edge; otherwise `tick`←0.
- RUN with `start`=1 and `stop`=0: `count`←0 (re-phase), no tick that edge, stay in RUN.
- RUN with `stop`=1: go to IDLE, `count`←0, `tick`←0, even if a wrap coincides.
- One-shot mode: on the wrap edge, `tick`←1 and `done`←1, and the block returns to IDLE with `count`←0.
- IDLE: `start`&&`stop` together leaves the block in IDLE.
- A config accept and a start on the same IDLE edge: start uses the previous ratio; the newly loaded ratio applies from the next start.
- Arithmetic: `count` is WIDTH bits unsigned and never exceeds N-1. N=1 gives `tick`=1 on every RUN cycle.
- Reset asserted mid-operation clears all state immediately, regardless of clock.

## Timing
- Start sampled at edge k: the first `tick` is high in the cycle after edge k+N, then every N cycles.
- `tick` and `done` are registered, exactly one cycle wide, and never back-to-back except when N=1.
- Stop sampled at edge j: `busy` is low after edge j, and no `tick` appears after edge j.
- `cfg_ready` goes high the cycle after RUN→IDLE.

## Configuration
- Macro `TICK_CTRL_ONESHOT_EN`.
- Defined: `cfg_mode` is honoured and `done` is functional.
- Undefined:
  - `cfg_mode` is ignored and the mode register is removed.
  - The block is always periodic.
  - `done` is tied to 0.

## Structure
- Package `tick_ctrl_pkg` holds:
  - the state enum (IDLE, RUN);
  - mode constants (MODE_PERIODIC=0, MODE_ONESHOT=1);
  - the `DEFAULT_DIV` default.
- Sub-module `tick_counter`: WIDTH-bit counter with clear, enable and terminal value N-1. It outputs a wrap strobe; the FSM registers that strobe into `tick`.

## Test plan
- Reset low then released, no inputs → `cfg_ready`=1, `tick`=0, `busy`=0, `count`=0. Start with the default ratio → first tick 6250000 cycles after the start edge (shorten with `DEFAULT_DIV`=8 in the bench).
- Config N=4, periodic, start at edge k → `tick` after edges k+4, k+8, k+12. `stop` at k+10 → no tick at k+12, and `busy`=0 after k+10.
- Config N=0, start → `tick`=1 every RUN cycle. Config N=1 → same behaviour.
- Config N=5, one-shot (macro defined), start → single tick and `done` after edge k+5, then IDLE with `cfg_ready`=1. Macro undefined → periodic ticks and `done`=0.
- N=6 running, `start` pulsed at count=3 → count resets, and the next tick comes 6 cycles later. `start`+`stop` in IDLE → stays IDLE.
- Reset asserted asynchronously mid-RUN at count=2 → all outputs return to reset values before the next clock edge, and the div register returns to `DEFAULT_DIV`.
